// File: rtl/rc5_key_loader_if.sv
// Purpose : signal bundle between the RC5 key loader, its control source,
//           the key byte RAM (read side) and the L word RAM (write side).
// Ports   : control (start, key_len, busy, done, c_out), key RAM read
//           (key_address, key_data), L RAM write (L_address, L_wdata, L_we).
// Modports: master = the loader itself; slave = controller and memories.
interface rc5_key_loader_if #(
    parameter int W     = 32,
    parameter int B_MAX = 16
) ();
    localparam int U     = W / 8;
    localparam int C_MAX = (B_MAX + U - 1) / U;
    localparam int KL    = $clog2(B_MAX + 1);
    localparam int KA    = (B_MAX > 1) ? $clog2(B_MAX) : 1;
    localparam int CA    = (C_MAX > 1) ? $clog2(C_MAX) : 1;

    // control
    logic          start;
    logic [KL-1:0] key_len;
    logic          busy;
    logic          done;
    logic [CA:0]   c_out;
    // key RAM read port
    logic [KA-1:0] key_address;
    logic [7:0]    key_data;
    // L RAM write port
    logic [CA-1:0] L_address;
    logic [W-1:0]  L_wdata;
    logic          L_we;

    modport master (
        input  start, key_len, key_data,
        output busy, done, c_out, key_address, L_address, L_wdata, L_we
    );

    modport slave (
        output start, key_len, key_data,
        input  busy, done, c_out, key_address, L_address, L_wdata, L_we
    );
endinterface

// File: rtl/rc5_key_loader.sv
// Purpose : RC5 key-expansion front end; packs b key bytes (little-endian)
//           into the L word array, one key byte fetched per cycle.
// Latency : b+3 cycles from accepted start to done (2 cycles when b=0).
// Backpressure: none; start is only honoured in IDLE, otherwise ignored.
// Ports   : clk, rst (async active-low), bus (rc5_key_loader_if.master):
//           start/key_len in, busy/done/c_out out, key RAM read address out
//           with byte returned one cycle later, L RAM write port out.
module rc5_key_loader #(
    parameter int W     = 32,
    parameter int B_MAX = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    rc5_key_loader_if.master      bus
);
    localparam int U     = W / 8;
    localparam int UL    = $clog2(U);
    localparam int C_MAX = (B_MAX + U - 1) / U;
    localparam int KL    = $clog2(B_MAX + 1);
    localparam int KA    = (B_MAX > 1) ? $clog2(B_MAX) : 1;
    localparam int CA    = (C_MAX > 1) ? $clog2(C_MAX) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ZERO  = 3'd1,
        FETCH = 3'd2,
        DRAIN = 3'd3,
        FIN   = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic          busy_c;
    logic          done_c;
    logic          accept;
    logic [KL-1:0] b_in;
    logic [KL:0]   b_round;
    logic [CA:0]   c_calc;

    logic [KA-1:0] key_address;
    logic [CA-1:0] l_address;
    logic [W-1:0]  l_wdata;
    logic          l_we;
    logic [CA:0]   c_out;

    // Word-local accumulator: holds at most U-1 bytes of the word being
    // built, the final byte completes the word straight into l_wdata.
    logic [W-9:0]  acc;
    logic [W-1:0]  fold;
    // Read pipeline: marks the cycle in which key_data belongs to rd_idx.
    logic          rd_vld;
    logic [KA-1:0] rd_idx;

    // Length latch inputs: oversize lengths clamp to B_MAX.
    assign b_in    = (bus.key_len > KL'(B_MAX)) ? KL'(B_MAX) : bus.key_len;
    assign b_round = {1'b0, b_in} + (KL + 1)'(U - 1);
    assign c_calc  = (b_in == '0) ? (CA + 1)'(1) : (CA + 1)'(b_round >> UL);
    assign accept  = (state == IDLE) && bus.start;

    // Bytes arrive highest index first, so shifting left places each new
    // byte below the previous ones: little-endian packing falls out.
    assign fold = {acc, bus.key_data};

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and status outputs
    always_comb begin
        state_nxt = state;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = (b_in == '0) ? ZERO : FETCH;
                end
            end
            ZERO: begin
                busy_c    = 1'b1;
                state_nxt = FIN;
            end
            FETCH: begin
                busy_c = 1'b1;
                // Address 0 is the last byte issued.
                if (key_address == '0) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy_c = 1'b1;
                // Word 0 is always the final write of a run.
                if (l_we && (l_address == '0)) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                done_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: address generation, byte folding, L writes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_address <= '0;
            l_address   <= '0;
            l_wdata     <= '0;
            l_we        <= 1'b0;
            c_out       <= '0;
            acc         <= '0;
            rd_vld      <= 1'b0;
            rd_idx      <= '0;
        end else begin
            l_we   <= 1'b0;
            rd_vld <= (state == FETCH);
            rd_idx <= key_address;

            if (accept) begin
                c_out <= c_calc;
                acc   <= '0;
                if (b_in == '0) begin
                    // Empty key: a single all-zero word.
                    l_we      <= 1'b1;
                    l_address <= '0;
                    l_wdata   <= '0;
                end else begin
                    key_address <= KA'(b_in - 1'b1);
                end
            end

            if ((state == FETCH) && (key_address != '0)) begin
                key_address <= key_address - 1'b1;
            end

            if (rd_vld) begin
                if (rd_idx[UL-1:0] == '0) begin
                    // Byte j*U closes word j; the next word starts empty.
                    l_we      <= 1'b1;
                    l_address <= CA'(rd_idx >> UL);
                    l_wdata   <= fold;
                    acc       <= '0;
                end else begin
                    acc <= fold[W-9:0];
                end
            end
        end
    end

    assign bus.busy        = busy_c;
    assign bus.done        = done_c;
    assign bus.c_out       = c_out;
    assign bus.key_address = key_address;
    assign bus.L_address   = l_address;
    assign bus.L_wdata     = l_wdata;
    assign bus.L_we        = l_we;
endmodule

// File: tb/tb_rc5_key_loader.sv
// Purpose : self-checking bench for rc5_key_loader at W=32/B_MAX=16 and
//           W=16/B_MAX=7, scoreboard of expected L writes and done pulses.
// Ports   : none (top level); two DUT instances share clk and rst.
module tb_rc5_key_loader;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int e0       = 0;

    typedef struct {
        int          addr;
        logic [63:0] data;
        int          cyc;
    } wr_t;

    wr_t q32[$];
    wr_t q16[$];
    int  dq32[$];
    int  dq16[$];
    wr_t w32, w16;
    int  d32, d16;

    logic [31:0] lmem32 [0:3];
    logic [7:0]  kmem32 [0:15];
    logic [7:0]  kmem16 [0:7];

    rc5_key_loader_if #(.W(32), .B_MAX(16)) bus32 ();
    rc5_key_loader_if #(.W(16), .B_MAX(7))  bus16 ();

    rc5_key_loader #(.W(32), .B_MAX(16)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
    rc5_key_loader #(.W(16), .B_MAX(7))  dut16 (.clk(clk), .rst(rst), .bus(bus16));

    // Synchronous key RAMs: data valid one cycle after the address.
    always @(posedge clk) bus32.key_data <= kmem32[bus32.key_address];
    always @(posedge clk) bus16.key_data <= kmem16[bus16.key_address];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // k is the offset from t0, so t0+k maps to edge count e0+k-1.
    task automatic push32(input int a, input logic [63:0] d, input int k);
        wr_t w;
        w.addr = a; w.data = d; w.cyc = e0 + k - 1;
        q32.push_back(w);
    endtask

    task automatic push16(input int a, input logic [63:0] d, input int k);
        wr_t w;
        w.addr = a; w.data = d; w.cyc = e0 + k - 1;
        q16.push_back(w);
    endtask

    // Monitor: every write and done pulse is popped and compared.
    always @(negedge clk) begin
        if (bus32.L_we) begin
            if (q32.size() == 0) begin
                chk("w32_unexpected_addr", 64'(bus32.L_address), 64'hFFFF);
            end else begin
                w32 = q32.pop_front();
                chk("w32_addr",  64'(bus32.L_address), 64'(w32.addr));
                chk("w32_data",  64'(bus32.L_wdata),   w32.data);
                chk("w32_cycle", 64'(cyc),             64'(w32.cyc));
            end
            lmem32[bus32.L_address] = bus32.L_wdata;
        end
        if (bus32.done) begin
            if (dq32.size() == 0) begin
                chk("done32_unexpected_cycle", 64'(cyc), 64'hFFFF);
            end else begin
                d32 = dq32.pop_front();
                chk("done32_cycle", 64'(cyc), 64'(d32));
                chk("done32_busy",  64'(bus32.busy), 64'd0);
            end
        end
        if (bus16.L_we) begin
            if (q16.size() == 0) begin
                chk("w16_unexpected_addr", 64'(bus16.L_address), 64'hFFFF);
            end else begin
                w16 = q16.pop_front();
                chk("w16_addr",  64'(bus16.L_address), 64'(w16.addr));
                chk("w16_data",  64'(bus16.L_wdata),   w16.data);
                chk("w16_cycle", 64'(cyc),             64'(w16.cyc));
            end
        end
        if (bus16.done) begin
            if (dq16.size() == 0) begin
                chk("done16_unexpected_cycle", 64'(cyc), 64'hFFFF);
            end else begin
                d16 = dq16.pop_front();
                chk("done16_cycle", 64'(cyc), 64'(d16));
            end
        end
    end

    task automatic arm32(input int kl);
        @(negedge clk); #1;
        bus32.start   = 1'b1;
        bus32.key_len = 5'(kl);
        e0 = cyc + 1;
    endtask

    // Runs in cycle t0+1: busy, first address and word count are visible.
    task automatic post32(input int kaddr, input int c, input bit chk_addr);
        @(negedge clk); #1;
        bus32.start = 1'b0;
        chk("busy32_t1", 64'(bus32.busy), 64'd1);
        chk("c_out32",   64'(bus32.c_out), 64'(c));
        if (chk_addr) chk("kaddr32_t1", 64'(bus32.key_address), 64'(kaddr));
    endtask

    task automatic arm16(input int kl);
        @(negedge clk); #1;
        bus16.start   = 1'b1;
        bus16.key_len = 3'(kl);
        e0 = cyc + 1;
    endtask

    task automatic post16(input int kaddr, input int c);
        @(negedge clk); #1;
        bus16.start = 1'b0;
        chk("busy16_t1",  64'(bus16.busy), 64'd1);
        chk("c_out16",    64'(bus16.c_out), 64'(c));
        chk("kaddr16_t1", 64'(bus16.key_address), 64'(kaddr));
    endtask

    task automatic wait32(input string name);
        for (int i = 0; i < 80; i++) begin
            @(negedge clk); #2;
            if (q32.size() == 0 && dq32.size() == 0) break;
        end
        chk(name, 64'(q32.size() + dq32.size()), 64'd0);
    endtask

    task automatic wait16(input string name);
        for (int i = 0; i < 80; i++) begin
            @(negedge clk); #2;
            if (q16.size() == 0 && dq16.size() == 0) break;
        end
        chk(name, 64'(q16.size() + dq16.size()), 64'd0);
    endtask

    task automatic chk_zero32(input string tag);
        chk({tag, "_busy"},  64'(bus32.busy),        64'd0);
        chk({tag, "_done"},  64'(bus32.done),        64'd0);
        chk({tag, "_we"},    64'(bus32.L_we),        64'd0);
        chk({tag, "_kaddr"}, 64'(bus32.key_address), 64'd0);
        chk({tag, "_laddr"}, 64'(bus32.L_address),   64'd0);
        chk({tag, "_wdata"}, 64'(bus32.L_wdata),     64'd0);
        chk({tag, "_c_out"}, 64'(bus32.c_out),       64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) kmem32[i] = 8'(i + 1);
        for (int i = 0; i < 8; i++)  kmem16[i] = 8'(8'hA0 + i);
        for (int i = 0; i < 4; i++)  lmem32[i] = 32'h0;
        bus32.start = 1'b0; bus32.key_len = '0;
        bus16.start = 1'b0; bus16.key_len = '0;

        // Reset state
        #3;
        chk_zero32("rst32");
        chk("rst16_busy", 64'(bus16.busy), 64'd0);
        chk("rst16_we",   64'(bus16.L_we), 64'd0);
        chk("rst16_c",    64'(bus16.c_out), 64'd0);
        @(negedge clk); #1 rst = 1'b1;
        repeat (2) @(negedge clk);

        // b=16: four full words, highest first
        arm32(16);
        push32(3, 64'h100F0E0D, 6);
        push32(2, 64'h0C0B0A09, 10);
        push32(1, 64'h08070605, 14);
        push32(0, 64'h04030201, 18);
        dq32.push_back(e0 + 18);
        post32(15, 4, 1);
        wait32("drain_b16");

        // b=5: partial top word; words 2 and 3 must stay untouched
        lmem32[2] = 32'hDEADBEEF;
        lmem32[3] = 32'hCAFEF00D;
        arm32(5);
        push32(1, 64'h00000005, 3);
        push32(0, 64'h04030201, 7);
        dq32.push_back(e0 + 7);
        post32(4, 2, 1);
        wait32("drain_b5");
        chk("b5_L2_untouched", 64'(lmem32[2]), 64'hDEADBEEF);
        chk("b5_L3_untouched", 64'(lmem32[3]), 64'hCAFEF00D);

        // b=0: a single zero word
        arm32(0);
        push32(0, 64'h0, 1);
        dq32.push_back(e0 + 1);
        post32(0, 1, 0);
        wait32("drain_b0");

        // key_len=20 clamps to 16; a second start during busy is ignored
        arm32(20);
        push32(3, 64'h100F0E0D, 6);
        push32(2, 64'h0C0B0A09, 10);
        push32(1, 64'h08070605, 14);
        push32(0, 64'h04030201, 18);
        dq32.push_back(e0 + 18);
        post32(15, 4, 1);
        repeat (3) @(negedge clk);
        @(negedge clk); #1;
        bus32.start   = 1'b1;
        bus32.key_len = 5'd3;
        @(negedge clk); #1;
        bus32.start = 1'b0;
        chk("clamp_c_out_held", 64'(bus32.c_out), 64'd4);
        wait32("drain_clamp");
        repeat (10) @(negedge clk);

        // Reset in cycle t0+6 of a b=16 run, after the first write
        arm32(16);
        push32(3, 64'h100F0E0D, 6);
        post32(15, 4, 1);
        repeat (5) @(negedge clk);
        #1 rst = 1'b0;
        #1 chk_zero32("midrst");
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("midrst_no_writes", 64'(q32.size() + dq32.size()), 64'd0);

        // Fresh run after reset: b=3
        arm32(3);
        push32(0, 64'h00030201, 5);
        dq32.push_back(e0 + 5);
        post32(2, 1, 1);
        wait32("drain_b3");

        // W=16, B_MAX=7, b=7
        arm16(7);
        push16(3, 64'h00A6, 3);
        push16(2, 64'hA5A4, 5);
        push16(1, 64'hA3A2, 7);
        push16(0, 64'hA1A0, 9);
        dq16.push_back(e0 + 9);
        post16(6, 4);
        wait16("drain_w16");
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
